// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV100 pipeline hazard unit: load-use, redirect and dmem-wait stall/flush control
module hazard_unit #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [2:0]       ID_ValidReg,
  input  logic             ID_MemWrite,
  input  logic [4:0]       EX_rd,
  input  logic [2:0]       EX_ValidReg,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_rd,
  input  logic [2:0]       MEM_ValidReg,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             EX_redirect,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_flush,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_TRIGGER = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  mw_cnt_q, mw_cnt_d;
  logic [CNT_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic              timeout_q, timeout_d;

  logic mem_busy, ex_hit, mem_hit, load_use;
  logic ex_match, mem_match;
  logic redirect_win, lu_win;

  // Hazard detection; store data (rs2 of a store) is covered by the MEM-stage forward
  always_comb begin
    ex_match  = (ID_ValidReg[1] && (ID_rs1 == EX_rd)) ||
                (ID_ValidReg[2] && (ID_rs2 == EX_rd) && !ID_MemWrite);
    mem_match = (ID_ValidReg[1] && (ID_rs1 == MEM_rd)) ||
                (ID_ValidReg[2] && (ID_rs2 == MEM_rd) && !ID_MemWrite);
    mem_busy  = (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
    ex_hit    = EX_MemRead && EX_ValidReg[0] && (EX_rd != 5'd0) && ex_match;
    mem_hit   = MEM_MemRead && MEM_ValidReg[0] && (MEM_rd != 5'd0) && mem_match;
    load_use  = ex_hit || mem_hit;
    redirect_win = !mem_busy && EX_redirect;
    lu_win       = !mem_busy && !EX_redirect && load_use;
  end

  // Priority-resolved pipeline controls, forced low while reset is held
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_stall = 1'b1;
        MEM_WB_flush = 1'b1;
      end else if (redirect_win) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
      end else if (lu_win) begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_flush  = 1'b1;
      end
    end
  end

  // Next state: wait FSM, wait counter, sticky timeout and saturating counters
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    lu_cnt_d  = lu_cnt_q;
    mw_cnt_d  = mw_cnt_q;
    fl_cnt_d  = fl_cnt_q;

    case (state_q)
      ST_RUN: begin
        wait_d = '0;
        if (mem_busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_busy) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          if (wait_q != WAIT_LIMIT) wait_d = wait_q + WAIT_W'(1);
          if (wait_q >= WAIT_TRIGGER) timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase

    if (cnt_clr) begin
      timeout_d = 1'b0;
      lu_cnt_d  = '0;
      mw_cnt_d  = '0;
      fl_cnt_d  = '0;
    end else begin
      if (lu_win && lu_cnt_q != CNT_MAX)       lu_cnt_d = lu_cnt_q + CNT_W'(1);
      if (mem_busy && mw_cnt_q != CNT_MAX)     mw_cnt_d = mw_cnt_q + CNT_W'(1);
      if (redirect_win && fl_cnt_q != CNT_MAX) fl_cnt_d = fl_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      lu_cnt_q  <= '0;
      mw_cnt_q  <= '0;
      fl_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      lu_cnt_q  <= lu_cnt_d;
      mw_cnt_q  <= mw_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign mem_wait_cnt = mw_cnt_q;
  assign flush_cnt    = fl_cnt_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit against a rule-level reference model
module tb_hazard_unit;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 3;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_rs1, ID_rs2, EX_rd, MEM_rd;
  logic [2:0] ID_ValidReg, EX_ValidReg, MEM_ValidReg;
  logic ID_MemWrite, EX_MemRead, MEM_MemRead, MEM_MemWrite;
  logic EX_redirect, dmem_ready, cnt_clr;
  logic pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush;
  logic [CNT_W-1:0] lu_stall_cnt, mem_wait_cnt, flush_cnt;
  logic mem_timeout;

  logic [6:0]       ctl;
  logic [3*CNT_W:0] cnt_obs;
  assign ctl     = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush};
  assign cnt_obs = {lu_stall_cnt, mem_wait_cnt, flush_cnt, mem_timeout};

  int checks = 0;
  int errors = 0;

  int unsigned m_lu, m_wait, m_flush, m_run;
  logic        m_to;

  hazard_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg), .ID_MemWrite(ID_MemWrite),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead),
    .MEM_rd(MEM_rd), .MEM_ValidReg(MEM_ValidReg), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .EX_redirect(EX_redirect), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .MEM_WB_flush(MEM_WB_flush),
    .lu_stall_cnt(lu_stall_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Does the decode instruction consume register r as an operand that forwarding cannot supply from a load
  function automatic logic reads(input logic [4:0] r);
    return (r != 5'd0) && ((ID_ValidReg[1] && ID_rs1 == r) ||
                           (ID_ValidReg[2] && ID_rs2 == r && !ID_MemWrite));
  endfunction

  function automatic logic m_busy();
    return (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
  endfunction

  function automatic logic m_lu_hit();
    return (EX_MemRead && EX_ValidReg[0] && reads(EX_rd)) ||
           (MEM_MemRead && MEM_ValidReg[0] && reads(MEM_rd));
  endfunction

  // {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush}
  function automatic logic [6:0] exp_ctl();
    if (!rst_n)       return 7'b0000000;
    if (m_busy())     return 7'b1101011;
    if (EX_redirect)  return 7'b0010100;
    if (m_lu_hit())   return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic logic [3*CNT_W:0] exp_cnt();
    logic [CNT_W-1:0] a, b, c;
    a = CNT_W'(m_lu);
    b = CNT_W'(m_wait);
    c = CNT_W'(m_flush);
    return {a, b, c, m_to};
  endfunction

  task automatic model_reset();
    m_lu = 0; m_wait = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
  endtask

  // Advance the model with the inputs present before the edge, then move to just past the edge
  task automatic tick();
    logic busy, redir, lu;
    busy  = m_busy();
    redir = !busy && EX_redirect;
    lu    = !busy && !EX_redirect && m_lu_hit();
    if (cnt_clr) begin
      m_lu = 0; m_wait = 0; m_flush = 0; m_to = 1'b0;
    end else begin
      if (lu && m_lu < CMAX)       m_lu++;
      if (busy && m_wait < CMAX)   m_wait++;
      if (redir && m_flush < CMAX) m_flush++;
      if (busy && m_run + 1 > MAX_WAIT) m_to = 1'b1;
    end
    m_run = busy ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; ID_ValidReg = 0; ID_MemWrite = 0;
    EX_rd = 0; EX_ValidReg = 0; EX_MemRead = 0;
    MEM_rd = 0; MEM_ValidReg = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
    EX_redirect = 0; dmem_ready = 1; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    idle();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    MEM_MemRead = 1; dmem_ready = 0; EX_redirect = 1;
    model_reset();
    #2;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, 7'b0); end
    @(posedge clk); #1;
    checks++;
    if (cnt_obs !== exp_cnt()) begin errors++; $display("FAIL reset_cnt: got %h exp %h", cnt_obs, exp_cnt()); end
    idle();
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    clear_counters();
    EX_MemRead = 1; EX_rd = 5; EX_ValidReg = 3'b001;
    ID_rs1 = 5; ID_rs2 = 1; ID_ValidReg = 3'b011;
    #2;
    checks++;
    if (ctl !== exp_ctl()) begin errors++; $display("FAIL lu_cycle0: got %b exp %b", ctl, exp_ctl()); end
    tick();
    EX_MemRead = 0; EX_ValidReg = 0; EX_rd = 0;
    MEM_MemRead = 1; MEM_rd = 5; MEM_ValidReg = 3'b001; dmem_ready = 1;
    #2;
    checks++;
    if (ctl !== 7'b1100100) begin errors++; $display("FAIL lu_cycle1: got %b exp %b", ctl, 7'b1100100); end
    tick();
    MEM_MemRead = 0; MEM_ValidReg = 0; MEM_rd = 0;
    #2;
    checks++;
    if (ctl !== exp_ctl()) begin errors++; $display("FAIL lu_release: got %b exp %b", ctl, exp_ctl()); end
    checks++;
    if (lu_stall_cnt !== CNT_W'(2) || cnt_obs !== exp_cnt())
      begin errors++; $display("FAIL lu_count: got %h exp %h", cnt_obs, exp_cnt()); end
  endtask

  task automatic test_store_and_x0();
    clear_counters();
    EX_MemRead = 1; EX_rd = 5; EX_ValidReg = 3'b001;
    ID_rs1 = 2; ID_rs2 = 5; ID_ValidReg = 3'b110; ID_MemWrite = 1;
    #2;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL store_data_exempt: got %b exp %b", ctl, 7'b0); end
    ID_rs1 = 5;
    #2;
    checks++;
    if (ctl !== exp_ctl()) begin errors++; $display("FAIL store_addr_dep: got %b exp %b", ctl, exp_ctl()); end
    tick();
    EX_MemRead = 0; EX_ValidReg = 0;
    MEM_MemRead = 1; MEM_rd = 5; MEM_ValidReg = 3'b001;
    #2;
    checks++;
    if (ctl !== exp_ctl()) begin errors++; $display("FAIL store_addr_mem: got %b exp %b", ctl, exp_ctl()); end
    tick();
    idle();
    EX_MemRead = 1; EX_rd = 0; EX_ValidReg = 3'b001;
    ID_rs1 = 0; ID_rs2 = 0; ID_ValidReg = 3'b111;
    #2;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL x0_no_stall: got %b exp %b", ctl, 7'b0); end
    tick();
    checks++;
    if (cnt_obs !== exp_cnt()) begin errors++; $display("FAIL store_count: got %h exp %h", cnt_obs, exp_cnt()); end
  endtask

  task automatic test_redirect_over_lu();
    clear_counters();
    EX_MemRead = 1; EX_rd = 7; EX_ValidReg = 3'b001;
    ID_rs1 = 7; ID_ValidReg = 3'b011; EX_redirect = 1;
    #2;
    checks++;
    if (ctl !== 7'b0010100) begin errors++; $display("FAIL redirect_ctl: got %b exp %b", ctl, 7'b0010100); end
    tick();
    idle();
    checks++;
    if (flush_cnt !== CNT_W'(1) || lu_stall_cnt !== CNT_W'(0) || cnt_obs !== exp_cnt())
      begin errors++; $display("FAIL redirect_cnt: got %h exp %h", cnt_obs, exp_cnt()); end
  endtask

  task automatic test_mem_wait_redirect();
    clear_counters();
    MEM_MemRead = 1; MEM_rd = 3; MEM_ValidReg = 3'b001; EX_redirect = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (ctl !== 7'b1101011) begin errors++; $display("FAIL wait_stall[%0d]: got %b exp %b", i, ctl, 7'b1101011); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++;
    if (ctl !== exp_ctl()) begin errors++; $display("FAIL wait_release: got %b exp %b", ctl, exp_ctl()); end
    tick();
    idle();
    checks++;
    if (mem_wait_cnt !== CNT_W'(3) || cnt_obs !== exp_cnt())
      begin errors++; $display("FAIL wait_cnt: got %h exp %h", cnt_obs, exp_cnt()); end
  endtask

  task automatic test_timeout();
    clear_counters();
    MEM_MemWrite = 1; dmem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (cnt_obs !== exp_cnt()) begin errors++; $display("FAIL timeout_step[%0d]: got %h exp %h", i, cnt_obs, exp_cnt()); end
    end
    // 1 RUN cycle + 5 WAIT cycles elapsed: flag raised after the 4th WAIT cycle
    dmem_ready = 1;
    tick();
    idle();
    tick();
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b exp %b", mem_timeout, 1'b1); end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++;
    if (cnt_obs !== '0) begin errors++; $display("FAIL timeout_clear: got %h exp %h", cnt_obs, 13'h0); end
  endtask

  task automatic test_reset_midwait();
    idle();
    MEM_MemRead = 1; dmem_ready = 0;
    tick(); tick(); tick();
    rst_n = 0;
    model_reset();
    #2;
    checks++;
    if (ctl !== 7'b0 || cnt_obs !== exp_cnt())
      begin errors++; $display("FAIL midwait_reset: ctl %b cnt %h exp 0", ctl, cnt_obs); end
    idle();
    #2 rst_n = 1;
    @(posedge clk); #1;
    MEM_MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (cnt_obs !== exp_cnt()) begin errors++; $display("FAIL midwait_restart: got %h exp %h", cnt_obs, exp_cnt()); end
    idle();
    tick();
  endtask

  task automatic test_random();
    clear_counters();
    for (int i = 0; i < 400; i++) begin
      ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
      ID_ValidReg = 3'($urandom); ID_MemWrite = ($urandom_range(0, 3) == 0);
      EX_rd = 5'($urandom_range(0, 3)); EX_ValidReg = 3'($urandom); EX_MemRead = $urandom_range(0, 1);
      MEM_rd = 5'($urandom_range(0, 3)); MEM_ValidReg = 3'($urandom);
      MEM_MemRead = ($urandom_range(0, 2) == 0); MEM_MemWrite = ($urandom_range(0, 3) == 0);
      EX_redirect = ($urandom_range(0, 4) == 0);
      dmem_ready = (i % 100 < 50) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      cnt_clr = ($urandom_range(0, 60) == 0);
      #2;
      checks++;
      if (ctl !== exp_ctl()) begin errors++; $display("FAIL rand_ctl[%0d]: got %b exp %b", i, ctl, exp_ctl()); end
      tick();
      checks++;
      if (cnt_obs !== exp_cnt()) begin errors++; $display("FAIL rand_cnt[%0d]: got %h exp %h", i, cnt_obs, exp_cnt()); end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_store_and_x0();
    test_redirect_over_lu();
    test_mem_wait_redirect();
    test_timeout();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage RV100 core. Sits beside the operand-forwarding logic and covers the hazards forwarding cannot resolve.
- Generates stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three cases: load-use interlock, control redirect from EX, and multi-cycle data-memory wait.
- Keeps saturating hazard performance counters and a sticky memory-timeout error.

Parameters:
CNT_W, 32, width of each performance counter
MAX_WAIT, 255, dmem wait cycles before timeout error is flagged
WAIT_W, 8, width of wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
ID_rs1  in  5  decode-stage source register 1
ID_rs2  in  5  decode-stage source register 2
ID_ValidReg  in  3  [0]=rd written, [1]=rs1 read, [2]=rs2 read
ID_MemWrite  in  1  decode instruction is a store
EX_rd  in  5  execute-stage destination
EX_ValidReg  in  3  execute-stage valid bits, same encoding
EX_MemRead  in  1  execute instruction is a load
MEM_rd  in  5  memory-stage destination
MEM_ValidReg  in  3  memory-stage valid bits
MEM_MemRead  in  1  memory instruction is a load
MEM_MemWrite  in  1  memory instruction is a store
EX_redirect  in  1  branch taken or jump resolved in EX
dmem_ready  in  1  data memory completes the access this cycle
cnt_clr  in  1  synchronous clear of all counters and the error flag
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  zero IF/ID (bubble)
ID_EX_stall  out  1  hold ID/EX
ID_EX_flush  out  1  insert bubble into ID/EX
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_flush  out  1  insert bubble into MEM/WB
lu_stall_cnt  out  CNT_W  load-use bubble cycles
mem_wait_cnt  out  CNT_W  dmem wait cycles
flush_cnt  out  CNT_W  redirects taken
mem_timeout  out  1  sticky: a wait exceeded MAX_WAIT

Behaviour:
- Reset (async, rst_n low): state=RUN, wait counter=0, all counters=0, mem_timeout=0. All control outputs are 0 while in reset.
- mem_busy = (MEM_MemRead|MEM_MemWrite) & !dmem_ready.
- ex_hit = EX_MemRead & EX_ValidReg[0] & EX_rd!=0 & match(EX_rd).
- mem_hit = MEM_MemRead & MEM_ValidReg[0] & MEM_rd!=0 & match(MEM_rd).
- match(r) = (ID_ValidReg[1] & ID_rs1==r) | (ID_ValidReg[2] & ID_rs2==r & !ID_MemWrite). Store data is exempt because the MEM-stage store-data forward covers it.
- load_use = ex_hit | mem_hit. A load is never forwarded from MEM, so a dependent instruction waits 2 cycles behind a load in EX.
- Priority, evaluated combinationally each cycle:
  1. mem_busy: pc_stall, IF_ID_stall, ID_EX_stall and EX_MEM_stall are all 1, and MEM_WB_flush=1. Redirect and load-use are suppressed.
  2. EX_redirect: IF_ID_flush=1 and ID_EX_flush=1, no stalls. Load-use is ignored because the ID instruction is on the wrong path.
  3. load_use: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1.
  4. Otherwise all controls are 0.
- FSM (registered):
  - RUN -> WAIT when mem_busy.
  - WAIT -> RUN on dmem_ready, or when neither MEM_MemRead nor MEM_MemWrite is set.
  - The wait counter increments each WAIT cycle and clears on entering RUN.
  - When the wait counter reaches MAX_WAIT, mem_timeout is set. It is sticky until cnt_clr or reset. The stall continues regardless; no abort.
- Counters update on the clock edge. Each saturates at 2^CNT_W-1 and does not wrap.
  - lu_stall_cnt increments when load_use is the winning condition.
  - mem_wait_cnt increments when mem_busy.
  - flush_cnt increments when EX_redirect wins.
- cnt_clr has priority over increments in the same cycle.
- Reset asserted mid-wait returns immediately to RUN with all outputs 0.

Test Plan:
- lw x5 in EX, ID add x6,x5,x1 (ID_ValidReg=3'b011) -> load_use for 2 cycles: cycle0 ex_hit, cycle1 mem_hit. pc_stall=IF_ID_stall=ID_EX_flush=1 both cycles; lu_stall_cnt=2.
- lw x5 in EX, ID sw x5,0(x2) with rs2=x5, rs1=x2 -> no stall. Change rs1 to x5 -> 2-cycle stall.
- Load to x0 in EX, ID reads x0 -> no stall.
- EX_redirect=1 with load_use also true -> IF_ID_flush=ID_EX_flush=1, pc_stall=0; flush_cnt=1, lu_stall_cnt unchanged.
- MEM_MemRead=1, dmem_ready low for 3 cycles then high, EX_redirect=1 throughout -> 3 cycles of full stall with MEM_WB_flush=1 and no flush. On the 4th cycle the redirect flush fires; mem_wait_cnt=3.
- MAX_WAIT=4, dmem_ready held low for 6 cycles -> mem_timeout=1 after the 4th WAIT cycle and stays 1 after ready. cnt_clr clears it and all counters to 0.
